// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment scanner with tear-free frame-boundary
// word updates and an all-off anode gap after each digit advance.
module seg7_scan #(
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        tick_in,
    input  logic        en,
    input  logic [31:0] data_in,
    input  logic        load,
    input  logic [7:0]  blank_in,
    input  logic [7:0]  dp_in,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        load_ack,
    output logic        frame_done
);

    localparam int         DATA_W   = 32;
    localparam logic [7:0] BLANK_LD = 8'(BLANK_CYCLES);

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic              tick_p0, tick_p1, tick_p2;
    logic [2:0]        idx;
    logic [7:0]        cnt;
    logic [DATA_W-1:0] pend_data, shd_data;
    logic [7:0]        pend_blank, pend_dp, shd_blank, shd_dp;
    logic              pend_vld;

    logic              tick_edge, wrap;
    logic [2:0]        idx_nx;
    logic [7:0]        cnt_nx;
    logic [DATA_W-1:0] shd_data_nx;
    logic [7:0]        shd_blank_nx, shd_dp_nx;
    logic [7:0]        an_nx;
    logic [6:0]        seg_nx;
    logic              dp_nx;

    // Stage: edge detect, next scan position and next shadow contents
    always_comb begin
        tick_edge    = tick_p1 & ~tick_p2;
        idx_nx       = idx;
        cnt_nx       = (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
        wrap         = 1'b0;
        shd_data_nx  = shd_data;
        shd_blank_nx = shd_blank;
        shd_dp_nx    = shd_dp;
        if (tick_edge) begin
            idx_nx = idx + 3'd1;
            cnt_nx = BLANK_LD;
            wrap   = (idx == 3'd7);
        end
        if (wrap && pend_vld) begin
            shd_data_nx  = pend_data;
            shd_blank_nx = pend_blank;
            shd_dp_nx    = pend_dp;
        end
        // Outputs follow the next-state so the digit drawn always matches the index latched with it
        an_nx = 8'hFF;
        if (cnt_nx == 8'd0 && en && !shd_blank_nx[idx_nx])
            an_nx = ~(8'd1 << idx_nx);
        seg_nx = hex7(shd_data_nx[{idx_nx, 2'b00} +: 4]);
        dp_nx  = ~shd_dp_nx[idx_nx];
    end

    // Stage: registered state and outputs
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            tick_p0    <= 1'b0;
            tick_p1    <= 1'b0;
            tick_p2    <= 1'b0;
            idx        <= 3'd0;
            cnt        <= 8'd0;
            pend_data  <= '0;
            pend_blank <= '0;
            pend_dp    <= '0;
            pend_vld   <= 1'b0;
            shd_data   <= '0;
            shd_blank  <= '0;
            shd_dp     <= '0;
            an         <= 8'hFF;
            seg        <= 7'h7F;
            dp_n       <= 1'b1;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tick_p0    <= tick_in;
            tick_p1    <= tick_p0;
            tick_p2    <= tick_p1;
            idx        <= idx_nx;
            cnt        <= cnt_nx;
            shd_data   <= shd_data_nx;
            shd_blank  <= shd_blank_nx;
            shd_dp     <= shd_dp_nx;
            // A load on the wrap cycle wins over the clear, so it waits for the next wrap
            if (load) begin
                pend_data  <= data_in;
                pend_blank <= blank_in;
                pend_dp    <= dp_in;
                pend_vld   <= 1'b1;
            end else if (wrap) begin
                pend_vld <= 1'b0;
            end
            an         <= an_nx;
            seg        <= seg_nx;
            dp_n       <= dp_nx;
            load_ack   <= wrap & pend_vld;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized and directed bench for seg7_scan against an event-timed reference
// model; runs one instance with a 4-cycle gap and one with no gap.
module tb_seg7_scan;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic        tick_in;
    logic        en;
    logic [31:0] data_in;
    logic        load;
    logic [7:0]  blank_in;
    logic [7:0]  dp_in;

    logic [7:0] an,   an_z;
    logic [6:0] seg,  seg_z;
    logic       dp_n, dp_n_z;
    logic       load_ack,   load_ack_z;
    logic       frame_done, frame_done_z;

    seg7_scan #(.BLANK_CYCLES(4)) u_dut (
        .clk_in(clk_in), .reset_n(reset_n), .tick_in(tick_in), .en(en),
        .data_in(data_in), .load(load), .blank_in(blank_in), .dp_in(dp_in),
        .an(an), .seg(seg), .dp_n(dp_n), .load_ack(load_ack), .frame_done(frame_done)
    );

    seg7_scan #(.BLANK_CYCLES(0)) u_dut_z (
        .clk_in(clk_in), .reset_n(reset_n), .tick_in(tick_in), .en(en),
        .data_in(data_in), .load(load), .blank_in(blank_in), .dp_in(dp_in),
        .an(an_z), .seg(seg_z), .dp_n(dp_n_z), .load_ack(load_ack_z), .frame_done(frame_done_z)
    );

    always #5 clk_in = ~clk_in;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: tick rises become scheduled advances two edges later
    logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int          edge_n = 0;
    int          due [$];
    bit          m_prev;
    int          m_idx;
    int          m_gap_end;
    logic [31:0] m_shd_d, m_pend_d;
    logic [7:0]  m_shd_b, m_shd_p, m_pend_b, m_pend_p;
    bit          m_pv;
    logic [7:0]  e_an4, e_an0;
    logic [6:0]  e_seg;
    logic        e_dp, e_ack, e_fd;
    int          fd_seen, ack_seen;

    task model_edge();
        bit         adv;
        logic [7:0] base;
        logic [3:0] nib;
        edge_n++;
        if (!reset_n) begin
            due.delete();
            m_prev = 0; m_idx = 0; m_gap_end = 0; m_pv = 0;
            m_shd_d = '0; m_shd_b = '0; m_shd_p = '0;
            m_pend_d = '0; m_pend_b = '0; m_pend_p = '0;
            e_an4 = 8'hFF; e_an0 = 8'hFF; e_seg = 7'h7F; e_dp = 1; e_ack = 0; e_fd = 0;
        end else begin
            adv = (due.size() > 0 && due[0] == edge_n);
            if (adv) void'(due.pop_front());
            if (tick_in && !m_prev) due.push_back(edge_n + 2);
            m_prev = tick_in;
            e_fd = 0; e_ack = 0;
            if (adv) begin
                m_idx     = (m_idx + 1) % 8;
                m_gap_end = edge_n + 4;
                if (m_idx == 0) begin
                    e_fd = 1;
                    if (m_pv) begin
                        m_shd_d = m_pend_d; m_shd_b = m_pend_b; m_shd_p = m_pend_p;
                        e_ack = 1; m_pv = 0;
                    end
                end
            end
            if (load) begin
                m_pend_d = data_in; m_pend_b = blank_in; m_pend_p = dp_in; m_pv = 1;
            end
            base  = (!en || m_shd_b[m_idx]) ? 8'hFF : ~(8'd1 << m_idx);
            e_an0 = base;
            e_an4 = (edge_n < m_gap_end) ? 8'hFF : base;
            nib   = m_shd_d[4*m_idx +: 4];
            e_seg = hex_tab[nib];
            e_dp  = ~m_shd_p[m_idx];
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
        chk("an",           {24'd0, an},         {24'd0, e_an4});
        chk("an_nogap",     {24'd0, an_z},       {24'd0, e_an0});
        chk("seg",          {25'd0, seg},        {25'd0, e_seg});
        chk("seg_nogap",    {25'd0, seg_z},      {25'd0, e_seg});
        chk("dp_n",         {31'd0, dp_n},       {31'd0, e_dp});
        chk("dp_n_nogap",   {31'd0, dp_n_z},     {31'd0, e_dp});
        chk("load_ack",     {31'd0, load_ack},   {31'd0, e_ack});
        chk("load_ack_ng",  {31'd0, load_ack_z}, {31'd0, e_ack});
        chk("frame_done",   {31'd0, frame_done}, {31'd0, e_fd});
        chk("frame_done_ng",{31'd0, frame_done_z},{31'd0, e_fd});
        if (frame_done) fd_seen++;
        if (load_ack)   ack_seen++;
    endtask

    task automatic rise(input int hi, input int lo);
        tick_in = 1'b1;
        repeat (hi) step();
        tick_in = 1'b0;
        repeat (lo) step();
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] b, input logic [7:0] p);
        data_in = d; blank_in = b; dp_in = p; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; tick_in = 1'b0; en = 1'b1; load = 1'b0;
        data_in = '0; blank_in = '0; dp_in = '0;

        // Reset with tick toggling
        for (int i = 0; i < 5; i++) begin
            tick_in = ~tick_in;
            step();
        end
        tick_in = 1'b0;
        reset_n = 1'b1;
        repeat (3) step();

        // First tick after reset selects digit 1
        rise(4, 4);
        chk("first_digit", {24'd0, an}, 32'h0000_00FD);

        // Full scan
        do_load(32'h89AB_CDEF, 8'h00, 8'h00);
        fd_seen = 0; ack_seen = 0;
        for (int i = 0; i < 16; i++) rise(4, 4);
        chk("scan_frames", fd_seen, 2);
        chk("scan_acks", ack_seen, 1);

        // Tear-free load from mid-frame
        for (int i = 0; i < 8 && m_idx != 3; i++) rise(4, 4);
        do_load(32'h1111_1111, 8'h00, 8'h00);
        step();
        do_load(32'h2222_2222, 8'h00, 8'h00);
        ack_seen = 0;
        for (int i = 0; i < 8 && m_idx != 0; i++) rise(4, 4);
        chk("tear_acks", ack_seen, 1);
        chk("tear_seg", {25'd0, seg}, 32'h24);

        // Load coincident with the wrap edge
        for (int i = 0; i < 8 && m_idx != 6; i++) rise(4, 4);
        do_load(32'h4444_4444, 8'h00, 8'h00);
        rise(4, 4);
        tick_in = 1'b1;
        step();
        step();
        data_in = 32'h3333_3333; load = 1'b1;
        step();
        load = 1'b0;
        chk("wrap_edge_ack", {31'd0, load_ack}, 32'd1);
        repeat (1) step();
        tick_in = 1'b0;
        repeat (4) step();
        chk("wrap_old_word", {25'd0, seg}, 32'h19);
        ack_seen = 0;
        for (int i = 0; i < 8; i++) rise(4, 4);
        chk("wrap_new_ack", ack_seen, 1);
        chk("wrap_new_word", {25'd0, seg}, 32'h30);

        // Masks, then enable off
        do_load(32'h7654_3210, 8'h81, 8'h02);
        for (int i = 0; i < 16; i++) rise(4, 4);
        en = 1'b0;
        for (int i = 0; i < 8; i++) rise(4, 4);
        en = 1'b1;

        // Randomized traffic, including one reset mid-gap
        for (int i = 0; i < 60; i++) begin
            int hi, lo;
            hi = $urandom_range(4, 8);
            lo = $urandom_range(4, 8);
            if (i == 30) begin
                tick_in = 1'b1;
                repeat (3) step();
                reset_n = 1'b0;
                repeat (2) step();
                reset_n = 1'b1;
                tick_in = 1'b0;
                repeat (4) step();
            end
            tick_in = 1'b1;
            for (int c = 0; c < hi + lo; c++) begin
                if (c == hi) tick_in = 1'b0;
                load     = ($urandom_range(0, 15) == 0);
                data_in  = $urandom;
                blank_in = 8'($urandom) & 8'($urandom);
                dp_in    = 8'($urandom);
                if ($urandom_range(0, 31) == 0) en = ~en;
                step();
            end
            load = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
